// File: rtl/id_issue_stage.sv
// Decode/issue stage between IF and EXE: valid/ready handshake, flush, load-use interlock,
// internal register file with WB bypass. Define ID_PERF_CNT_EN to add a saturating stall counter.
module id_issue_stage #(
    parameter int          XLEN     = 32,
    parameter int          REG_NUM  = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          PERF_W   = 16,
    localparam int         AW       = $clog2(REG_NUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_load,
    input  logic [AW-1:0]   ex_rd,
    output logic            id_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [AW-1:0]   id_rd
`ifdef ID_PERF_CNT_EN
    ,
    input  logic            cnt_clr,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    // Register indices must fit the 5-bit instruction fields.
    if (AW > 5 || PERF_W < 1) begin : g_param_check
        $error("id_issue_stage: REG_NUM must be <= 32 and PERF_W >= 1");
    end

    logic            occ;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     inst_r;
    logic [XLEN-1:0] regs [REG_NUM];

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            hazard;
    logic            fire_out;
    logic            capture;

    assign rs1 = AW'(inst_r[19:15]);
    assign rs2 = AW'(inst_r[24:20]);

    assign hazard   = occ && ex_load && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));
    assign id_valid = occ && !hazard && !flush;
    assign fire_out = id_valid && ex_ready;
    assign if_ready = !flush && (!occ || fire_out);
    assign capture  = if_valid && if_ready;

    assign id_pc   = pc_r;
    assign id_inst = inst_r;
    assign id_rd   = AW'(inst_r[11:7]);

    // NOTE: every output of always_comb is given a default first, so no path can infer a latch.
    always_comb begin
        id_rs1_data = regs[rs1];
        if (rs1 == '0)
            id_rs1_data = '0;
        else if (wb_we && (wb_addr == rs1))
            id_rs1_data = wb_data;
    end

    always_comb begin
        id_rs2_data = regs[rs2];
        if (rs2 == '0)
            id_rs2_data = '0;
        else if (wb_we && (wb_addr == rs2))
            id_rs2_data = wb_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ    <= 1'b0;
            pc_r   <= '0;
            inst_r <= NOP_INST;
        end else if (flush) begin
            occ    <= 1'b0;
            inst_r <= NOP_INST;
        end else if (capture) begin
            occ    <= 1'b1;
            pc_r   <= if_pc;
            inst_r <= if_inst;
        end else if (fire_out) begin
            occ    <= 1'b0;
            inst_r <= NOP_INST;
        end
    end

    // NOTE: the register file is architecturally cleared on reset, so it is reset like flops, not left as RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++)
                regs[i] <= '0;
        end else if (wb_we && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

`ifdef ID_PERF_CNT_EN
    // Saturating count of interlock cycles; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (cnt_clr)
            stall_cnt <= '0;
        else if (hazard && (stall_cnt != '1))
            stall_cnt <= stall_cnt + PERF_W'(1);
    end
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: directed scenarios plus random traffic against a spec-level model.
module tb_id_issue_stage;

    localparam int          XLEN    = 32;
    localparam int          REG_NUM = 32;
    localparam int          AW      = 5;
    localparam int          PERF_W  = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            flush;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ex_load;
    logic [AW-1:0]   ex_rd;
    logic            id_valid;
    logic            ex_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [AW-1:0]   id_rd;
`ifdef ID_PERF_CNT_EN
    logic              cnt_clr;
    logic [PERF_W-1:0] stall_cnt;
`endif

    id_issue_stage #(
        .XLEN    (XLEN),
        .REG_NUM (REG_NUM),
        .NOP_INST(NOP),
        .PERF_W  (PERF_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_load    (ex_load),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .ex_ready   (ex_ready),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data),
        .id_rd      (id_rd)
`ifdef ID_PERF_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is either empty or holds one instruction.
    logic            m_occ;
    logic [XLEN-1:0] m_pc;
    logic [31:0]     m_inst;
    logic [XLEN-1:0] m_regs [REG_NUM];
    int              m_cnt;
    localparam int   CNT_MAX = (1 << PERF_W) - 1;

    function automatic logic [XLEN-1:0] m_operand(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
        if (wb_we && wb_addr == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic m_hazard();
        return m_occ && ex_load && ex_rd != 0 &&
               (ex_rd == m_inst[19:15] || ex_rd == m_inst[24:20]);
    endfunction

    function automatic logic m_offer();
        return m_occ && !m_hazard() && !flush;
    endfunction

    function automatic logic m_accept();
        return !flush && (!m_occ || (m_offer() && ex_ready));
    endfunction

    always @(posedge clk or posedge rst) begin : model_update
        logic hz;
        logic acc;
        logic leave;
        if (rst) begin
            m_occ  <= 1'b0;
            m_pc   <= '0;
            m_inst <= NOP;
            m_cnt  <= 0;
            for (int i = 0; i < REG_NUM; i++) m_regs[i] <= '0;
        end else begin
            hz    = m_hazard();
            acc   = if_valid && m_accept();
            leave = m_offer() && ex_ready;
            if (wb_we && wb_addr != 0) m_regs[wb_addr] <= wb_data;
            if (flush) begin
                m_occ  <= 1'b0;
                m_inst <= NOP;
            end else if (acc) begin
                m_occ  <= 1'b1;
                m_pc   <= if_pc;
                m_inst <= if_inst;
            end else if (leave) begin
                m_occ  <= 1'b0;
                m_inst <= NOP;
            end
`ifdef ID_PERF_CNT_EN
            if (cnt_clr) m_cnt <= 0;
            else if (hz && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
`endif
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        check("cyc id_valid", id_valid, m_offer());
        check("cyc if_ready", if_ready, m_accept());
        check("cyc id_pc", id_pc, m_pc);
        check("cyc id_inst", id_inst, m_inst);
        check("cyc id_rd", id_rd, m_inst[11:7]);
        check("cyc rs1_data", id_rs1_data, m_operand(m_inst[19:15]));
        check("cyc rs2_data", id_rs2_data, m_operand(m_inst[24:20]));
`ifdef ID_PERF_CNT_EN
        check("cyc stall_cnt", stall_cnt, m_cnt);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r        = $urandom;
        r[24:20] = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        rst = 1'b1;
        if_valid = 1'b0; if_pc = '0; if_inst = NOP; flush = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        ex_load = 1'b0; ex_rd = '0; ex_ready = 1'b0;
`ifdef ID_PERF_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        check("idle id_valid", id_valid, 1'b0);
        check("idle if_ready", if_ready, 1'b1);
        check("idle id_inst", id_inst, 32'h0000_0013);
        check("idle rs1", id_rs1_data, 32'h0);
        check("idle rs2", id_rs2_data, 32'h0);

        // Write x5 in the same cycle the reading instruction is captured.
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        if_valid = 1'b1; if_pc = 32'h40; if_inst = 32'h0052_8533;
        step();
        wb_we = 1'b0; if_valid = 1'b0;
        settle();
        check("wr x5 rs1", id_rs1_data, 32'hDEAD_BEEF);
        check("wr x5 rs2", id_rs2_data, 32'hDEAD_BEEF);
        check("wr x5 id_valid", id_valid, 1'b1);
        check("wr x5 id_pc", id_pc, 32'h40);
        check("wr x5 id_rd", id_rd, 5'd10);
        ex_ready = 1'b1;
        step();
        if_valid = 1'b1; if_pc = 32'h44; if_inst = 32'h0000_0033; ex_ready = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
        step();
        if_valid = 1'b0;
        settle();
        check("x0 rs1", id_rs1_data, 32'h0);
        check("x0 rs2", id_rs2_data, 32'h0);

        // Back-to-back stream with EXE always ready.
        step();
        wb_we = 1'b0; ex_ready = 1'b1; if_valid = 1'b1;
        if_pc = 32'h100; if_inst = 32'h0010_0093;
        settle();
        check("stream if_ready", if_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            if_pc = 32'h104 + 32'(4 * k);
            settle();
            check("stream id_pc", id_pc, 32'h100 + 32'(4 * k));
            check("stream id_valid", id_valid, 1'b1);
            check("stream if_ready", if_ready, 1'b1);
        end

        // Load-use interlock on rs1 = x5.
        step();
        if_pc = 32'h300; if_inst = 32'h0002_81B3;
        step();
        ex_load = 1'b1; ex_rd = 5'd5; if_pc = 32'h200; if_inst = NOP;
        settle();
        check("stall id_valid", id_valid, 1'b0);
        check("stall if_ready", if_ready, 1'b0);
        check("stall id_pc", id_pc, 32'h300);
        step();
        settle();
        check("stall2 id_valid", id_valid, 1'b0);
        check("stall2 id_pc", id_pc, 32'h300);
        step();
        ex_load = 1'b0;
        settle();
        check("unstall id_valid", id_valid, 1'b1);
        check("unstall if_ready", if_ready, 1'b1);
`ifdef ID_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 4'd2);
`endif

        // Backpressure, then flush.
        step();
        ex_ready = 1'b0; if_pc = 32'h204;
        settle();
        check("bp if_ready", if_ready, 1'b0);
        check("bp id_pc", id_pc, 32'h200);
        step();
        settle();
        check("bp hold id_pc", id_pc, 32'h200);
        step();
        flush = 1'b1;
        settle();
        check("flush id_valid", id_valid, 1'b0);
        check("flush if_ready", if_ready, 1'b0);
        step();
        flush = 1'b0; if_valid = 1'b0;
        settle();
        check("post flush id_valid", id_valid, 1'b0);
        check("post flush id_inst", id_inst, 32'h0000_0013);

        // Reset in the middle of a stall clears state and the register file.
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h11;
        step();
        wb_addr = 5'd2; wb_data = 32'h22;
        step();
        wb_addr = 5'd3; wb_data = 32'h33;
        if_valid = 1'b1; if_pc = 32'h500; if_inst = 32'h0020_8033;
        step();
        wb_we = 1'b0; if_valid = 1'b0; ex_load = 1'b1; ex_rd = 5'd2;
        settle();
        check("pre rst rs1", id_rs1_data, 32'h11);
        check("pre rst rs2", id_rs2_data, 32'h22);
        check("pre rst id_valid", id_valid, 1'b0);
        step();
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h99;
        #1 rst = 1'b1;
        #1;
        check("rst id_valid", id_valid, 1'b0);
        check("rst if_ready", if_ready, 1'b1);
        check("rst id_pc", id_pc, 32'h0);
        check("rst id_inst", id_inst, 32'h0000_0013);
        check("rst rs1", id_rs1_data, 32'h0);
        step();
        rst = 1'b0; wb_we = 1'b0; ex_load = 1'b0; ex_ready = 1'b1;
        if_valid = 1'b1; if_pc = 32'h600; if_inst = 32'h0020_8033;
        step();
        if_pc = 32'h604; if_inst = 32'h0001_8013;
        settle();
        check("cleared x1", id_rs1_data, 32'h0);
        check("cleared x2", id_rs2_data, 32'h0);
        step();
        if_valid = 1'b0;
        settle();
        check("cleared x3", id_rs1_data, 32'h0);
        check("cleared id_pc", id_pc, 32'h604);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            if_valid = ($urandom_range(0, 3) != 0);
            if_pc    = $urandom;
            if_inst  = rand_inst();
            flush    = ($urandom_range(0, 15) == 0);
            wb_we    = 1'($urandom_range(0, 1));
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            ex_load  = ($urandom_range(0, 2) == 0);
            ex_rd    = 5'($urandom_range(0, 7));
            ex_ready = ($urandom_range(0, 3) != 0);
`ifdef ID_PERF_CNT_EN
            cnt_clr  = ($urandom_range(0, 127) == 0);
`endif
        end
        step();
        settle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
